// File: rtl/hit_ctl.sv
// Gun-side shot controller: trigger edge -> hitbox test -> shot/miss strobes, ammo, score, flash.
// Build option: define TRIGGER_SYNC_EN when trigger is asynchronous to i_aclk (adds a 2-flop synchroniser).
module hit_ctl #(
    parameter int DUCK_W    = 64,
    parameter int DUCK_H    = 64,
    parameter int AMMO      = 3,
    parameter int SHOT_HOLD = 4,
    parameter int COOLDOWN  = 16
) (
    input  logic        i_aclk,
    input  logic        i_rst,
    input  logic        i_trigger,
    input  logic [10:0] i_cur_x,
    input  logic [10:0] i_cur_y,
    input  logic [10:0] i_duck_x,
    input  logic [10:0] i_duck_y,
    input  logic [2:0]  i_duck_state,
    output logic        o_shot,
    output logic [1:0]  o_ammo,
    output logic [9:0]  o_score,
    output logic        o_miss,
    output logic        o_flash
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRE  = 3'd1,
        S_HOLD  = 3'd2,
        S_COOL  = 3'd3,
        S_EMPTY = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_LD   = 8'(SHOT_HOLD - 1);
    localparam logic [7:0] COOL_LD   = 8'(COOLDOWN - 1);
    localparam logic [1:0] AMMO_FULL = 2'(AMMO);
    localparam logic [9:0] SCORE_MAX = 10'd999;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_trig_s;
    logic        r_trig_prev;
    logic [2:0]  r_dstate_prev;
    logic [7:0]  r_cnt;
    logic [1:0]  r_ammo;
    logic [9:0]  r_score;
    logic        r_shot;
    logic        r_miss;
    logic        r_flash;
    logic        w_fire;
    logic        w_reload;
    logic        w_hit;
    logic        w_tc;
    logic        w_enter_fire;
    logic [1:0]  w_ammo_base;
    logic [11:0] w_cx;
    logic [11:0] w_cy;
    logic [11:0] w_dx_lo;
    logic [11:0] w_dy_lo;
    logic [11:0] w_dx_hi;
    logic [11:0] w_dy_hi;

`ifdef TRIGGER_SYNC_EN
    logic r_sync1;

    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1     <= 1'b0;
            r_trig_s    <= 1'b0;
            r_trig_prev <= 1'b0;
        end else begin
            r_sync1     <= i_trigger;
            r_trig_s    <= r_sync1;
            r_trig_prev <= r_trig_s;
        end
    end
`else
    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            r_trig_s    <= 1'b0;
            r_trig_prev <= 1'b0;
        end else begin
            r_trig_s    <= i_trigger;
            r_trig_prev <= r_trig_s;
        end
    end
`endif

    assign w_fire   = r_trig_s & ~r_trig_prev;
    // A new duck spawns when the controller leaves FALLING for an alive state.
    assign w_reload = (r_dstate_prev == 3'd6) && (i_duck_state <= 3'd4);

    assign w_cx    = {1'b0, i_cur_x};
    assign w_cy    = {1'b0, i_cur_y};
    assign w_dx_lo = {1'b0, i_duck_x};
    assign w_dy_lo = {1'b0, i_duck_y};
    assign w_dx_hi = w_dx_lo + 12'(DUCK_W);
    assign w_dy_hi = w_dy_lo + 12'(DUCK_H);
    assign w_hit   = (i_duck_state <= 3'd4) &&
                     (w_cx >= w_dx_lo) && (w_cx < w_dx_hi) &&
                     (w_cy >= w_dy_lo) && (w_cy < w_dy_hi);

    assign w_tc         = (r_cnt == 8'd0);
    assign w_enter_fire = (r_state == S_IDLE) && w_fire && (r_ammo != 2'd0);
    assign w_ammo_base  = w_reload ? AMMO_FULL : r_ammo;

    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_enter_fire) w_state_nxt = S_FIRE;
            S_FIRE:  w_state_nxt = S_HOLD;
            S_HOLD:  if (w_tc) w_state_nxt = S_COOL;
            // A reload landing on the exit edge must not strand us in EMPTY with full ammo.
            S_COOL:  if (w_tc) w_state_nxt = ((r_ammo == 2'd0) && !w_reload) ? S_EMPTY : S_IDLE;
            S_EMPTY: if (w_reload) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or posedge i_rst) begin
        if (i_rst) begin
            r_dstate_prev <= 3'd6;
            r_cnt         <= 8'd0;
            r_ammo        <= AMMO_FULL;
            r_score       <= 10'd0;
            r_shot        <= 1'b0;
            r_miss        <= 1'b0;
            r_flash       <= 1'b0;
        end else begin
            r_dstate_prev <= i_duck_state;
            r_ammo        <= w_enter_fire ? (w_ammo_base - 2'd1) : w_ammo_base;
            r_miss        <= 1'b0;

            if (r_state == S_FIRE) begin
                r_cnt <= HOLD_LD;
            end else if ((r_state == S_HOLD) && w_tc) begin
                r_cnt <= COOL_LD;
            end else if (((r_state == S_HOLD) || (r_state == S_COOL)) && !w_tc) begin
                r_cnt <= r_cnt - 8'd1;
            end

            if (r_state == S_FIRE) begin
                r_shot <= w_hit;
                r_miss <= ~w_hit;
                if (w_hit && (r_score < SCORE_MAX)) begin
                    r_score <= r_score + 10'd1;
                end
            end else if ((r_state == S_HOLD) && w_tc) begin
                r_shot <= 1'b0;
            end

            if (w_enter_fire) begin
                r_flash <= 1'b1;
            end else if ((r_state == S_HOLD) && w_tc) begin
                r_flash <= 1'b0;
            end
        end
    end

    assign o_shot  = r_shot;
    assign o_ammo  = r_ammo;
    assign o_score = r_score;
    assign o_miss  = r_miss;
    assign o_flash = r_flash;

endmodule
